// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing controller.
// Holds the controller state enum, the halt opcode and default sizing constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [6:0] HALT_OPCODE      = 7'b0000001;
  localparam int         REG_ADDR_W_DEF   = 5;
  localparam int         DRAIN_CYCLES_DEF = 3;
  localparam int         CNT_W_DEF        = 32;

  function automatic logic is_halt_opcode(input logic [6:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and its consumer in ID.
// A halt in ID never raises the hazard: it is turned into a bubble anyway.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_halt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_MemRead,
  output logic                  lu
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_rd_live = ex_MemRead && (ex_rd != '0);
  assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  assign lu = w_rd_live && (w_rs1_hit || w_rs2_hit) && !id_halt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush, redirect, memory wait and halt drain.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_PERF_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
`ifdef PIPE_PERF_EN
  , parameter int CNT_W      = CNT_W_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_halt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  ex_pc_sel,
  input  logic                  mem_busy,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic                  halted
`ifdef PIPE_PERF_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam int                DCNT_W     = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DCNT_W-1:0] r_cnt;
  logic [DCNT_W-1:0] w_cnt_nxt;
  logic              r_halted;
  logic              w_lu;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_halt    (id_halt),
    .ex_rd      (ex_rd),
    .ex_MemRead (ex_MemRead),
    .lu         (w_lu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= (w_state_nxt == HALTED);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;

    case (r_state)
      RUN: begin
        // Memory wait outranks everything: the whole pipe holds, so any
        // redirect or halt stays presented and is acted on once it clears.
        if (mem_busy) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end else if (ex_pc_sel) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_lu) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_halt) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_state_nxt = DRAIN;
          w_cnt_nxt   = DRAIN_INIT;
        end
      end

      DRAIN: begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (mem_busy) begin
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          // <= also catches a zero count so a corrupted drain cannot hang
          if (r_cnt <= DRAIN_LAST) begin
            w_state_nxt = HALTED;
          end
        end
      end

      HALTED: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end

      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign halted = r_halted;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counting only in RUN freezes both counters through the halt sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state == RUN) begin
      if (pc_stall) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (ex_pc_sel && !mem_busy) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a priority-table model of the controller.
module tb_pipeline_ctrl;

  localparam int RW    = 5;
  localparam int DRAIN = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, id_halt, ex_MemRead, ex_pc_sel, mem_busy;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, mem_wb_flush, halted;
`ifdef PIPE_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  logic [7:0]    w_out;
  int            n_cmp = 0;
  int            n_err = 0;

  // Model state: draining cycles left, parked flag, perf counts
  int            m_left   = 0;
  bit            m_halted = 1'b0;
  int unsigned   m_stall  = 0;
  int unsigned   m_flush  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_ADDR_W   (RW),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_halt      (id_halt),
    .ex_rd        (ex_rd),
    .ex_MemRead   (ex_MemRead),
    .ex_pc_sel    (ex_pc_sel),
    .mem_busy     (mem_busy),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_flush (mem_wb_flush),
    .halted       (halted)
`ifdef PIPE_PERF_EN
    , .stall_cnt  (stall_cnt)
    , .flush_cnt  (flush_cnt)
`endif
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, halted}
  assign w_out = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                  id_ex_flush, ex_mem_stall, mem_wb_flush, halted};

  function automatic bit model_lu();
    return ex_MemRead && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)) &&
           !id_halt;
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o = 8'b0;
    if (m_halted)            o = 8'b1101_0111;
    else if (m_left > 0)     o = mem_busy ? 8'b1011_1110 : 8'b1010_1000;
    else if (mem_busy)       o = 8'b1101_0110;
    else if (ex_pc_sel)      o = 8'b0010_1000;
    else if (model_lu())     o = 8'b1100_1000;
    else if (id_halt)        o = 8'b1010_1000;
    return o;
  endfunction

  always @(posedge clk) begin
    logic [7:0] o;
    o = model_out();
    if (reset) begin
      m_left = 0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (m_left > 0) begin
        if (!mem_busy) begin
          m_left = m_left - 1;
          if (m_left == 0) m_halted = 1'b1;
        end
      end else begin
        if (o[7]) m_stall = m_stall + 1;
        if (!mem_busy && ex_pc_sel) m_flush = m_flush + 1;
        if (!mem_busy && !ex_pc_sel && !model_lu() && id_halt) m_left = DRAIN;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, then compare against the model
  task automatic cyc(input bit r, input bit busy, input bit sel, input bit halt,
                     input bit mr, input logic [RW-1:0] rd,
                     input logic [RW-1:0] rs1, input bit u1,
                     input logic [RW-1:0] rs2, input bit u2, input bit do_cmp);
    @(negedge clk);
    reset = r; mem_busy = busy; ex_pc_sel = sel; id_halt = halt;
    ex_MemRead = mr; ex_rd = rd; id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2;
    #1;
    if (do_cmp) begin
      chk("model_outputs", {24'b0, w_out}, {24'b0, model_out()});
`ifdef PIPE_PERF_EN
      chk("model_stall_cnt", stall_cnt, m_stall);
      chk("model_flush_cnt", flush_cnt, m_flush);
`endif
    end
  endtask

  task automatic idle(input bit do_cmp);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, do_cmp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_busy = 0; ex_pc_sel = 0; id_halt = 0; ex_MemRead = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    cyc(1'b1, 0, 0, 0, 0, '0, '0, 0, '0, 0, 1'b0);
    cyc(1'b1, 0, 0, 0, 0, '0, '0, 0, '0, 0, 1'b1);

    // Reset state
    idle(1'b1);
    chk("reset_outputs", {24'b0, w_out}, 32'h00);

    // Load-use on rs1, then the bubble lets the consumer advance
    cyc(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1'b1);
    chk("lu_rs1", {24'b0, w_out}, 32'b1100_1000);
    idle(1'b1);
    chk("lu_one_cycle", {24'b0, w_out}, 32'h00);
    cyc(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 1'b1);
    chk("lu_x0_no_stall", {24'b0, w_out}, 32'h00);
    cyc(0, 0, 0, 0, 1, 5'd7, 5'd1, 1, 5'd7, 1, 1'b1);
    chk("lu_rs2", {24'b0, w_out}, 32'b1100_1000);

    // Redirect beats load-use and a wrong-path halt
    cyc(0, 0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1'b1);
    chk("redirect", {24'b0, w_out}, 32'b0010_1000);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("redirect_no_halt", {31'b0, halted}, 32'd0);
    end

    // Memory wait with a pending redirect
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 0, '0, '0, 0, '0, 0, 1'b1);
      chk("mem_wait", {24'b0, w_out}, 32'b1101_0110);
    end
    cyc(0, 0, 1, 0, 0, '0, '0, 0, '0, 0, 1'b1);
    chk("mem_wait_then_flush", {24'b0, w_out}, 32'b0010_1000);

    // Halt: halt cycle, three drain cycles, then parked on cycle 5
    cyc(0, 0, 0, 1, 0, '0, '0, 0, '0, 0, 1'b1);
    chk("halt_cycle", {24'b0, w_out}, 32'b1010_1000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0, 1'b1);
      chk("drain", {24'b0, w_out}, 32'b1010_1000);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, i == 1, i == 2, 1, 0, '0, '0, 0, '0, 0, 1'b1);
      chk("halted_frozen", {24'b0, w_out}, 32'b1101_0111);
    end

    // Reset out of HALTED
    cyc(1'b1, 0, 0, 0, 0, '0, '0, 0, '0, 0, 1'b1);
    idle(1'b1);
    chk("reset_from_halted", {24'b0, w_out}, 32'h00);
`ifdef PIPE_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
`endif

    // Halt with two busy cycles inside DRAIN delays halted by two cycles
    cyc(0, 0, 0, 1, 0, '0, '0, 0, '0, 0, 1'b1);
    cyc(0, 1, 0, 0, 0, '0, '0, 0, '0, 0, 1'b1);
    chk("drain_busy", {24'b0, w_out}, 32'b1011_1110);
    cyc(0, 1, 0, 0, 0, '0, '0, 0, '0, 0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("drain_busy_not_yet", {31'b0, halted}, 32'd0);
    idle(1'b1);
    chk("drain_busy_halted", {31'b0, halted}, 32'd1);
    cyc(1'b1, 0, 0, 0, 0, '0, '0, 0, '0, 0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 1) == 1,
          RW'($urandom_range(0, 3)),
          RW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          RW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
